// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file sizing, index type and zero-register constant
package cpu_pkg;
  localparam int AW_DEFAULT = 5;
  localparam int NREG_DEFAULT = 32;
  localparam int ZERO_REG = 0;
  typedef logic [AW_DEFAULT-1:0] reg_idx_t;
endpackage

// File: rtl/sb_counter.sv
// sb_counter: per-register pending-write up/down counter with clear and zero/max flags
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             max
);
  assign zero = cnt == '0;
  assign max = &cnt;
  always_ff @(posedge clk)
    if (reset || clr) cnt <= '0;
    else if (inc && !dec && !max) cnt <= cnt + 1'b1;
    else if (dec && !inc && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: in-order RAW/capacity hazard scoreboard driving the ID-stage stall
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT,
  parameter int AW = $clog2(NREG),
  parameter int CNT_W = 2,
  parameter int WB_BYPASS = 0,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic              iss_allowin,
  input  logic [AW-1:0]     iss_rs1,
  input  logic              iss_rs1_use,
  input  logic [AW-1:0]     iss_rs2,
  input  logic              iss_rs2_use,
  input  logic              iss_we,
  input  logic [AW-1:0]     iss_dest,
  input  logic              wb_valid,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_dest,
  input  logic              flush,
  output logic              stall,
  output logic              iss_fire,
  output logic [NREG-1:0]   busy_vec,
  output logic              err_underflow,
  output logic [PERF_W-1:0] stall_cycles
);
  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0] zero, max;
  logic wb_ret, haz1, haz2, cap;
  assign wb_ret = wb_valid & wb_we;
  // Register 0 looks permanently idle, so it can never hazard or underflow.
  assign cnt[0] = '0;
  assign zero[0] = 1'b1;
  assign max[0] = 1'b0;
  genvar r;
  for (r = 1; r < NREG; r++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk(clk),
      .reset(reset),
      .inc(iss_fire & iss_we & (iss_dest == AW'(r))),
      .dec(wb_ret & (wb_dest == AW'(r))),
      .clr(flush),
      .cnt(cnt[r]),
      .zero(zero[r]),
      .max(max[r])
    );
  end
  // Write-through bypass only helps when the retiring write is the last one in flight.
  assign haz1 = iss_rs1_use & (iss_rs1 != AW'(ZERO_REG)) & ~zero[iss_rs1] &
                ~((WB_BYPASS != 0) & (cnt[iss_rs1] == CNT_W'(1)) & wb_ret & (wb_dest == iss_rs1));
  assign haz2 = iss_rs2_use & (iss_rs2 != AW'(ZERO_REG)) & ~zero[iss_rs2] &
                ~((WB_BYPASS != 0) & (cnt[iss_rs2] == CNT_W'(1)) & wb_ret & (wb_dest == iss_rs2));
  assign cap = iss_we & (iss_dest != AW'(ZERO_REG)) & max[iss_dest];
  assign stall = iss_valid & (haz1 | haz2 | cap);
  assign iss_fire = iss_valid & ~stall & iss_allowin;
  assign busy_vec = ~zero;
  always_ff @(posedge clk)
    if (reset) err_underflow <= 1'b0;
    else if (wb_ret && wb_dest != AW'(ZERO_REG) && zero[wb_dest]) err_underflow <= 1'b1;
  always_ff @(posedge clk)
    if (reset) stall_cycles <= '0;
    else if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
endmodule
